// File: rtl/branch_predict_unit.sv
// Branch predict unit: direct-mapped BTB with 2-bit counters for fetch-side
// next-PC prediction, plus execute-side branch resolve, redirect and table update.
module branch_predict_unit #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ENTRIES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] i_f_pc,
  output logic            o_f_taken,
  output logic [XLEN-1:0] o_f_npc,
  input  logic            i_ex_valid,
  input  logic [6:0]      i_ex_op,
  input  logic [2:0]      i_ex_funct3,
  input  logic [XLEN-1:0] i_ex_pc,
  input  logic [XLEN-1:0] i_ex_imm,
  input  logic [XLEN-1:0] i_ex_rs1,
  input  logic [XLEN-1:0] i_ex_rs2,
  input  logic [XLEN-1:0] i_ex_pred_npc,
  output logic            o_ex_taken,
  output logic [XLEN-1:0] o_ex_npc,
  output logic            o_ex_mispredict,
  output logic [31:0]     o_miss_cnt
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = XLEN - 2 - IDX_W;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  logic             valid_q [ENTRIES];
  logic [1:0]       ctr_q   [ENTRIES];
  logic [TAG_W-1:0] tag_q   [ENTRIES];
  logic [XLEN-1:0]  tgt_q   [ENTRIES];
  logic             jmp_q   [ENTRIES];
  logic [31:0]      miss_cnt_q, miss_cnt_d;

  logic [IDX_W-1:0] f_idx;
  logic             f_hit;

  logic             is_branch, is_jump, is_ctrl;
  logic             cond, res_taken;
  logic [XLEN-1:0]  res_tgt, seq_pc;

  logic [IDX_W-1:0] ex_idx;
  logic [TAG_W-1:0] ex_tag;
  logic             ex_hit;
  logic             valid_we, valid_d;
  logic             ctr_we;
  logic [1:0]       ctr_d;
  logic             data_we;

  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{i_f_pc[1:0], i_ex_pc[1:0]};

  // Fetch lookup from registered table state
  always_comb begin
    f_idx     = i_f_pc[IDX_W+1:2];
    f_hit     = valid_q[f_idx] && (tag_q[f_idx] == i_f_pc[XLEN-1:IDX_W+2]);
    o_f_taken = f_hit && (jmp_q[f_idx] || ctr_q[f_idx][1]);
    o_f_npc   = o_f_taken ? tgt_q[f_idx] : i_f_pc + XLEN'(4);
  end

  // Execute-side resolve; everything reads as zero for an invalid slot
  always_comb begin
    is_branch = (i_ex_op == OP_BRANCH);
    is_jump   = (i_ex_op == OP_JAL) || (i_ex_op == OP_JALR);
    is_ctrl   = is_branch || is_jump;
    seq_pc    = i_ex_pc + XLEN'(4);
    cond      = 1'b0;
    case (i_ex_funct3)
      3'b000:  cond = (i_ex_rs1 == i_ex_rs2);
      3'b001:  cond = (i_ex_rs1 != i_ex_rs2);
      3'b100:  cond = ($signed(i_ex_rs1) <  $signed(i_ex_rs2));
      3'b101:  cond = ($signed(i_ex_rs1) >= $signed(i_ex_rs2));
      3'b110:  cond = (i_ex_rs1 <  i_ex_rs2);
      3'b111:  cond = (i_ex_rs1 >= i_ex_rs2);
      default: cond = 1'b0;
    endcase
    res_taken = is_jump || (is_branch && cond);
    if (i_ex_op == OP_JALR) res_tgt = (i_ex_rs1 + i_ex_imm) & ~XLEN'(3);
    else                    res_tgt = i_ex_pc + i_ex_imm;

    o_ex_taken      = i_ex_valid && res_taken;
    o_ex_npc        = '0;
    if (i_ex_valid) o_ex_npc = res_taken ? res_tgt : seq_pc;
    o_ex_mispredict = i_ex_valid && (i_ex_pred_npc != o_ex_npc);
  end

  // Table update controls for the entry addressed by the execute PC
  always_comb begin
    ex_idx   = i_ex_pc[IDX_W+1:2];
    ex_tag   = i_ex_pc[XLEN-1:IDX_W+2];
    ex_hit   = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    valid_we = 1'b0;
    valid_d  = 1'b0;
    ctr_we   = 1'b0;
    ctr_d    = ctr_q[ex_idx];
    data_we  = 1'b0;
    if (i_ex_valid) begin
      if (is_ctrl && ex_hit) begin
        data_we = 1'b1;
        ctr_we  = 1'b1;
        if (res_taken) ctr_d = (ctr_q[ex_idx] == 2'd3) ? 2'd3 : ctr_q[ex_idx] + 2'd1;
        else           ctr_d = (ctr_q[ex_idx] == 2'd0) ? 2'd0 : ctr_q[ex_idx] - 2'd1;
      end else if (is_ctrl && res_taken) begin
        data_we  = 1'b1;
        valid_we = 1'b1;
        valid_d  = 1'b1;
        ctr_we   = 1'b1;
        ctr_d    = is_jump ? 2'd3 : 2'd2;
      end else if (!is_ctrl && ex_hit) begin
        valid_we = 1'b1;
        valid_d  = 1'b0;
      end
    end
    miss_cnt_d = (o_ex_mispredict && (miss_cnt_q != 32'hFFFF_FFFF)) ?
                 miss_cnt_q + 32'd1 : miss_cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'b01;
      end
      miss_cnt_q <= '0;
    end else begin
      if (valid_we) valid_q[ex_idx] <= valid_d;
      if (ctr_we)   ctr_q[ex_idx]   <= ctr_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  // Payload fields are qualified by valid, so they carry no reset
  always_ff @(posedge clk) begin
    if (data_we) begin
      tag_q[ex_idx] <= ex_tag;
      tgt_q[ex_idx] <= res_tgt;
      jmp_q[ex_idx] <= is_jump;
    end
  end

  assign o_miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit: directed steps followed by
// random traffic, all compared against an array-based BTB model.
module tb_branch_predict_unit;

  localparam logic [6:0] BR   = 7'b1100011;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111;
  localparam logic [6:0] ALU  = 7'b0010011;

  logic        clk, rst;
  logic [31:0] f_pc, f_npc;
  logic        f_taken;
  logic        ex_valid;
  logic [6:0]  ex_op;
  logic [2:0]  ex_f3;
  logic [31:0] ex_pc, ex_imm, ex_rs1, ex_rs2, ex_pred;
  logic        ex_taken, ex_mis;
  logic [31:0] ex_npc, miss_cnt;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model state
  bit          mv   [16];
  logic [31:0] mtag [16];
  logic [31:0] mtgt [16];
  bit          mjmp [16];
  int          mctr [16];
  logic [31:0] mmiss;

  // Resolution of the instruction currently driven (pre-edge)
  logic        r_taken, r_ctrl, r_jump;
  logic [31:0] r_npc, r_tgt;

  branch_predict_unit #(.XLEN(32), .ENTRIES(16)) dut (
    .clk(clk), .rst(rst),
    .i_f_pc(f_pc), .o_f_taken(f_taken), .o_f_npc(f_npc),
    .i_ex_valid(ex_valid), .i_ex_op(ex_op), .i_ex_funct3(ex_f3),
    .i_ex_pc(ex_pc), .i_ex_imm(ex_imm), .i_ex_rs1(ex_rs1), .i_ex_rs2(ex_rs2),
    .i_ex_pred_npc(ex_pred),
    .o_ex_taken(ex_taken), .o_ex_npc(ex_npc), .o_ex_mispredict(ex_mis),
    .o_miss_cnt(miss_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int unsigned idx_of(input logic [31:0] pc);
    return (pc / 4) % 16;
  endfunction

  function automatic bit hit_of(input logic [31:0] pc);
    return mv[idx_of(pc)] && (mtag[idx_of(pc)] == pc / 64);
  endfunction

  function automatic bit mpred_taken(input logic [31:0] pc);
    return hit_of(pc) && (mjmp[idx_of(pc)] || mctr[idx_of(pc)] >= 2);
  endfunction

  function automatic logic [31:0] mpred_npc(input logic [31:0] pc);
    return mpred_taken(pc) ? mtgt[idx_of(pc)] : pc + 32'd4;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      mv[i] = 0;
      mctr[i] = 1;
    end
    mmiss = 32'd0;
  endtask

  task automatic model_resolve();
    bit c;
    c = 0;
    case (ex_f3)
      3'd0: c = (ex_rs1 == ex_rs2);
      3'd1: c = (ex_rs1 != ex_rs2);
      3'd4: c = ($signed(ex_rs1) <  $signed(ex_rs2));
      3'd5: c = ($signed(ex_rs1) >= $signed(ex_rs2));
      3'd6: c = (ex_rs1 <  ex_rs2);
      3'd7: c = (ex_rs1 >= ex_rs2);
      default: c = 0;
    endcase
    r_jump  = (ex_op == JAL) || (ex_op == JALR);
    r_ctrl  = r_jump || (ex_op == BR);
    r_taken = r_jump || ((ex_op == BR) && c);
    r_tgt   = (ex_op == JALR) ? ((ex_rs1 + ex_imm) & 32'hFFFF_FFFC) : ex_pc + ex_imm;
    r_npc   = r_taken ? r_tgt : ex_pc + 32'd4;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs (at negedge) and compare every output to the model
  task automatic drive(input logic v, input logic [6:0] op, input logic [2:0] f3,
                       input logic [31:0] pc, input logic [31:0] imm,
                       input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [31:0] pred, input logic [31:0] fpc);
    bit emis;
    ex_valid = v; ex_op = op; ex_f3 = f3; ex_pc = pc; ex_imm = imm;
    ex_rs1 = rs1; ex_rs2 = rs2; ex_pred = pred; f_pc = fpc;
    #1;
    model_resolve();
    emis = v && (pred != r_npc);
    chk("f_taken", 32'(f_taken), 32'(mpred_taken(fpc)));
    chk("f_npc", f_npc, mpred_npc(fpc));
    chk("ex_taken", 32'(ex_taken), v ? 32'(r_taken) : 32'd0);
    chk("ex_npc", ex_npc, v ? r_npc : 32'd0);
    chk("ex_mispredict", 32'(ex_mis), 32'(emis));
    chk("miss_cnt", miss_cnt, mmiss);
  endtask

  // Advance through the rising edge and apply the same update to the model
  task automatic tick();
    int unsigned i;
    bit h;
    i = idx_of(ex_pc);
    h = hit_of(ex_pc);
    @(posedge clk);
    if (ex_valid) begin
      if (ex_pred != r_npc && mmiss != 32'hFFFF_FFFF) mmiss = mmiss + 32'd1;
      if (r_ctrl && h) begin
        mtgt[i] = r_tgt;
        mjmp[i] = r_jump;
        if (r_taken) mctr[i] = (mctr[i] == 3) ? 3 : mctr[i] + 1;
        else         mctr[i] = (mctr[i] == 0) ? 0 : mctr[i] - 1;
      end else if (r_ctrl && r_taken) begin
        mv[i] = 1; mtag[i] = ex_pc / 64; mtgt[i] = r_tgt; mjmp[i] = r_jump;
        mctr[i] = r_jump ? 3 : 2;
      end else if (!r_ctrl && h) begin
        mv[i] = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic [31:0] fpc);
    drive(1'b0, ALU, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, fpc);
  endtask

  initial begin
    logic [31:0] base [2];
    logic [31:0] pc, fpc, imm, rs1, rs2, pred;
    logic [6:0]  op;
    int          sel;
    base[0] = 32'h0000_1000;
    base[1] = 32'h0000_5400;

    rst = 1'b1;
    ex_valid = 1'b0; ex_op = '0; ex_f3 = '0; ex_pc = '0; ex_imm = '0;
    ex_rs1 = '0; ex_rs2 = '0; ex_pred = '0; f_pc = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    idle(32'h100);
    chk("t1_f_taken", 32'(f_taken), 32'd0);
    chk("t1_f_npc", f_npc, 32'h104);
    chk("t1_miss", miss_cnt, 32'd0);
    tick();

    // BEQ taken, first encounter, allocates
    drive(1'b1, BR, 3'd0, 32'h100, 32'h20, 32'd5, 32'd5, 32'h104, 32'h100);
    chk("t2_npc", ex_npc, 32'h120);
    chk("t2_mis", 32'(ex_mis), 32'd1);
    chk("t2_same_cycle_lookup", f_npc, 32'h104);
    tick();
    idle(32'h100);
    chk("t2_miss_cnt", miss_cnt, 32'd1);
    chk("t2_f_npc", f_npc, 32'h120);
    tick();

    // Counter walks down 2->1->0 then stays at 0
    drive(1'b1, BR, 3'd0, 32'h100, 32'h20, 32'd1, 32'd2, 32'h120, 32'h100);
    chk("t3_mis1", 32'(ex_mis), 32'd1);
    tick();
    drive(1'b1, BR, 3'd0, 32'h100, 32'h20, 32'd1, 32'd2, 32'h104, 32'h100);
    chk("t3_fallback", f_npc, 32'h104);
    chk("t3_mis2", 32'(ex_mis), 32'd0);
    tick();
    drive(1'b1, BR, 3'd0, 32'h100, 32'h20, 32'd1, 32'd2, 32'h104, 32'h100);
    chk("t3_mis3", 32'(ex_mis), 32'd0);
    tick();
    drive(1'b1, BR, 3'd0, 32'h100, 32'h20, 32'd7, 32'd7, 32'h104, 32'h100);
    tick();
    idle(32'h100);
    chk("t3_ctr_floor", f_npc, 32'h104);
    tick();

    // JALR clears low target bits and predicts taken as a jump
    drive(1'b1, JALR, 3'd0, 32'h200, 32'd2, 32'h1003, 32'd0, 32'h204, 32'h200);
    chk("t4_npc", ex_npc, 32'h1004);
    tick();
    idle(32'h200);
    chk("t4_f_taken", 32'(f_taken), 32'd1);
    chk("t4_f_npc", f_npc, 32'h1004);
    tick();

    // Signed vs unsigned compares
    drive(1'b1, BR, 3'd4, 32'h300, 32'h8, 32'hFFFF_FFFF, 32'd1, 32'h304, 32'h300);
    chk("t5_blt", 32'(ex_taken), 32'd1);
    tick();
    drive(1'b1, BR, 3'd6, 32'h300, 32'h8, 32'hFFFF_FFFF, 32'd1, 32'h304, 32'h300);
    chk("t5_bltu", 32'(ex_taken), 32'd0);
    tick();
    drive(1'b1, BR, 3'd7, 32'h300, 32'h8, 32'hFFFF_FFFF, 32'd1, 32'h304, 32'h300);
    chk("t5_bgeu", 32'(ex_taken), 32'd1);
    tick();
    drive(1'b1, BR, 3'd2, 32'h300, 32'h8, 32'hFFFF_FFFF, 32'd1, 32'h304, 32'h300);
    chk("t5_f3_010", 32'(ex_taken), 32'd0);
    tick();

    // Aliasing on index 0 and the non-control scrub
    drive(1'b1, BR, 3'd0, 32'h40, 32'h10, 32'd0, 32'd0, 32'h44, 32'h40);
    tick();
    drive(1'b1, JAL, 3'd0, 32'h440, 32'h100, 32'd0, 32'd0, 32'h444, 32'h40);
    chk("t6_pre_alias", f_npc, 32'h50);
    tick();
    idle(32'h40);
    chk("t6_alias_miss", f_npc, 32'h44);
    tick();
    drive(1'b1, ALU, 3'd0, 32'h440, 32'h100, 32'd0, 32'd0, 32'h540, 32'h440);
    chk("t6_scrub_mis", 32'(ex_mis), 32'd1);
    chk("t6_hit_before_scrub", f_npc, 32'h540);
    tick();
    idle(32'h440);
    chk("t6_scrubbed", f_npc, 32'h444);
    tick();

    // Miss counter saturation
    force dut.miss_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.miss_cnt_q;
    mmiss = 32'hFFFF_FFFE;
    drive(1'b1, JAL, 3'd0, 32'h600, 32'h40, 32'd0, 32'd0, 32'h604, 32'h600);
    tick();
    drive(1'b1, JAL, 3'd0, 32'h600, 32'h40, 32'd0, 32'd0, 32'h604, 32'h600);
    chk("t6_cnt_max", miss_cnt, 32'hFFFF_FFFF);
    tick();
    idle(32'h600);
    chk("t6_cnt_sat", miss_cnt, 32'hFFFF_FFFF);
    tick();

    // Random traffic against the model
    for (int n = 0; n < 300; n++) begin
      pc  = base[$urandom_range(0, 1)] | (32'($urandom_range(0, 3)) << 2);
      fpc = base[$urandom_range(0, 1)] | (32'($urandom_range(0, 3)) << 2);
      sel = $urandom_range(0, 4);
      op  = (sel <= 1) ? BR : (sel == 2) ? JAL : (sel == 3) ? JALR : ALU;
      imm = ($urandom_range(0, 3) == 0) ? -(32'($urandom_range(1, 64)) << 2)
                                       : 32'($urandom_range(0, 64)) << 2;
      rs1 = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      rs2 = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      case ($urandom_range(0, 3))
        0, 1: pred = mpred_npc(pc);
        2:    pred = pc + 32'd4;
        default: pred = $urandom;
      endcase
      drive(($urandom_range(0, 9) < 8), op, 3'($urandom_range(0, 7)),
            pc, imm, rs1, rs2, pred, fpc);
      tick();
    end

    // Reset asserted mid-cycle with an update pending
    drive(1'b1, JAL, 3'd0, 32'h1004, 32'h80, 32'd0, 32'd0, 32'h0, 32'h1000);
    tick();
    drive(1'b1, JAL, 3'd0, 32'h1004, 32'h80, 32'd0, 32'd0, 32'h0, 32'h1004);
    chk("t7_hit_before_rst", f_npc, 32'h1084);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("t7_rst_f_taken", 32'(f_taken), 32'd0);
    chk("t7_rst_f_npc", f_npc, 32'h1008);
    chk("t7_rst_miss", miss_cnt, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(32'h1004);
    chk("t7_after_rst", f_npc, 32'h1008);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
